// File: rtl/shift_rows_serial.sv
// shift_rows_serial: byte-serial AES ShiftRows stage feeding a byte-serial
// MixColumns stage. A 16-byte state arrives column-major, one byte per cycle,
// into one bank of a ping-pong pair. It leaves in ShiftRows order, column by
// column, with column and state start markers.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset (control state and outputs)
//   in_valid        in_byte is valid this cycle
//   in_byte         state byte, k-th byte of a state is index row + 4*col
//   in_ready        combinational; current write bank is not full
//   out_valid       registered; out_byte is valid
//   out_byte        registered ShiftRows-ordered byte
//   out_col_start   registered; first (row 0) byte of each output column
//   out_state_start registered; first byte of each output state
module shift_rows_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_col_start,
  output logic       out_state_start
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BANKS  = 2;

  logic [BYTE_W-1:0] mem [BANKS][DEPTH];

  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic             wr_fire;
  logic             rd_fire;
  logic             wr_last;
  logic             rd_last;
  logic [1:0]       rd_row;
  logic [1:0]       rd_col;
  logic [1:0]       rd_src_col;
  logic [CNT_W-1:0] rd_idx;

  // Readiness depends only on the registered full flags.
  assign in_ready = !full[wr_bank];

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = full[rd_bank];
  assign wr_last = (wr_cnt == CNT_W'(DEPTH - 1));
  assign rd_last = (rd_cnt == CNT_W'(DEPTH - 1));

  // Output row r of column c comes from input column (c + r) mod 4.
  assign rd_row     = rd_cnt[1:0];
  assign rd_col     = rd_cnt[3:2];
  assign rd_src_col = rd_col + rd_row;
  assign rd_idx     = {rd_src_col, rd_row};

  // Full flags: the writer sets one bank and the reader clears the other;
  // they can never target the same bank on the same edge.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_last) full_nxt[rd_bank] = 1'b0;
  end

  // Bank storage is not reset; stale contents are never read without a
  // full flag.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= in_byte;
  end

  // Write-side control.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      full    <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        if (wr_last) wr_bank <= !wr_bank;
      end
    end
  end

  // Read side: drains a full bank in 16 consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank         <= 1'b0;
      rd_cnt          <= '0;
      out_valid       <= 1'b0;
      out_byte        <= '0;
      out_col_start   <= 1'b0;
      out_state_start <= 1'b0;
    end else if (rd_fire) begin
      out_byte        <= mem[rd_bank][rd_idx];
      out_valid       <= 1'b1;
      out_col_start   <= (rd_row == 2'd0);
      out_state_start <= (rd_cnt == '0);
      rd_cnt          <= rd_cnt + CNT_W'(1);
      if (rd_last) rd_bank <= !rd_bank;
    end else begin
      out_valid       <= 1'b0;
      out_col_start   <= 1'b0;
      out_state_start <= 1'b0;
    end
  end

endmodule
